// File: rtl/ov5640_cfg_pkg.sv
// ov5640_cfg_pkg
// Shared definitions for the OV5640 power-up / configuration sequencer:
// sequencer state encoding, the delay-entry marker and the field layout of
// a 32-bit table entry {ID, REG_H, REG_L, DATA}.
// No ports (package).
package ov5640_cfg_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    PWDN_REL = 3'd1,
    RST_REL  = 3'd2,
    RUN      = 3'd3,
    DLY      = 3'd4,
    DONE     = 3'd5
  } cfg_state_t;

  // An entry whose ID byte equals this is a millisecond delay, not a bus write.
  localparam logic [7:0] DELAY_ID = 8'hFF;

  // Entry field positions.
  localparam int ID_MSB   = 31;
  localparam int ID_LSB   = 24;
  localparam int REGH_MSB = 23;
  localparam int REGH_LSB = 16;
  localparam int REGL_MSB = 15;
  localparam int REGL_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  // Delay length in ms occupies the low half of a delay entry.
  localparam int DLY_MSB  = 15;
  localparam int DLY_LSB  = 0;

  function automatic logic [7:0] entry_id(input logic [31:0] entry);
    return entry[ID_MSB:ID_LSB];
  endfunction

  function automatic logic [15:0] entry_delay_ms(input logic [31:0] entry);
    return entry[DLY_MSB:DLY_LSB];
  endfunction

endpackage

// File: rtl/ov5640_cfg_lut.sv
// ov5640_cfg_lut
// OV5640 register table as a synchronous case ROM (one-cycle read latency).
// Entries are {ID, REG_H, REG_L, DATA}; ID 8'hFF marks a delay of DATA16 ms.
// Ports:
//   clk   in   1   system clock
//   addr  in  10   table index
//   data  out 32   registered entry; 32'h0 for addresses past the table
module ov5640_cfg_lut
  import ov5640_cfg_pkg::*;
(
  input  logic        clk,
  input  logic [9:0]  addr,
  output logic [31:0] data
);

  // Registered table read.
  always_ff @(posedge clk) begin
    case (addr)
      10'd0:   data <= 32'h7831_0311; // clock from pad
      10'd1:   data <= 32'h7830_0882; // software reset
      10'd2:   data <= 32'hFF00_0005; // wait 5 ms for reset to settle
      10'd3:   data <= 32'h7830_0842; // software power down
      10'd4:   data <= 32'h7831_0303; // clock from PLL
      10'd5:   data <= 32'hFF00_0000; // zero-length delay
      10'd6:   data <= 32'h7830_17FF; // FREX/VSYNC/HREF/PCLK/D[9:6] output
      10'd7:   data <= 32'h7830_18FF; // D[5:0]/GPIO output
      10'd8:   data <= 32'h7830_341A; // PLL: 10-bit mode
      10'd9:   data <= 32'h7830_3713; // PLL root divider / pre-divider
      10'd10:  data <= 32'h7831_0801; // PCLK/SCLK dividers
      10'd11:  data <= 32'h7836_3036; // analog control
      default: data <= 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// ov5640_cfg_sequencer
// Drives the OV5640 PWDN/RESETB power-on timing, holds the SCCB controller
// in reset until the sensor is ready, then serves the controller one table
// entry at a time through its index/data/size interface. Delay entries are
// executed locally and never reach the bus.
// Build option: define OV5640_CFG_DELAY_EN to decode delay entries (ID 8'hFF)
// and build the DLY state; without it every entry is passed verbatim and the
// size limit is fixed at LUT_SIZE.
// Ports:
//   clk               in   1  system clock
//   rst               in   1  synchronous active-high reset
//   cmos_pwdn         out  1  sensor power-down (1 = powered down)
//   cmos_rst_n        out  1  sensor RESETB (0 = in reset)
//   i2c_rst_n         out  1  SCCB controller reset (0 = held)
//   i2c_config_index  in  10  entry index requested by the controller
//   i2c_config_size   out 10  limit that gates the controller
//   i2c_config_data   out 32  entry for the current index
//   cfg_done          out  1  every entry consumed; sticky until rst
module ov5640_cfg_sequencer
  import ov5640_cfg_pkg::*;
#(
  parameter int         CLK_FREQ  = 100_000_000,
  parameter logic [9:0] LUT_SIZE  = 10'd300,
  parameter int         T_PWDN_MS = 5,
  parameter int         T_RST_MS  = 1,
  parameter int         T_SCCB_MS = 20
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cmos_pwdn,
  output logic        cmos_rst_n,
  output logic        i2c_rst_n,
  input  logic [9:0]  i2c_config_index,
  output logic [9:0]  i2c_config_size,
  output logic [31:0] i2c_config_data,
  output logic        cfg_done
);

  localparam logic [31:0] TICK_LAST = 32'(CLK_FREQ / 1000 - 1);

  cfg_state_t  state_r;
  logic [31:0] tick_cnt_r;
  logic [15:0] ms_cnt_r;
  logic        go_r;        // start a lookup on the next cycle
  logic [1:0]  lk_r;        // lookup stage: 1 = ROM read, 2 = decode
  logic [9:0]  ptr_r;
  logic [9:0]  idx_prev_r;
  logic [31:0] rom_data_s;
  logic [9:0]  ptr_nxt_s;
  logic [15:0] wait_ms_s;
  logic        ms_tick_s;
  logic        wait_over_s;
  logic        start_s;
  logic        resolve_s;
  cfg_state_t  dec_state_s;
  logic [9:0]  dec_size_s;
  logic        dec_load_s;
  logic        dec_done_s;
`ifdef OV5640_CFG_DELAY_EN
  logic [9:0]  skip_r;      // delay entries already executed
  logic [15:0] dly_ms_r;
  assign ptr_nxt_s = i2c_config_index + skip_r;
`else
  assign ptr_nxt_s = i2c_config_index;
`endif

  ov5640_cfg_lut u_lut (
    .clk  (clk),
    .addr (ptr_r),
    .data (rom_data_s)
  );

  // Length in ms of the wait belonging to the current state.
  always_comb begin
    wait_ms_s = 16'd0;
    case (state_r)
      PWR_WAIT: wait_ms_s = 16'(T_PWDN_MS);
      PWDN_REL: wait_ms_s = 16'(T_RST_MS);
      RST_REL:  wait_ms_s = 16'(T_SCCB_MS);
`ifdef OV5640_CFG_DELAY_EN
      DLY:      wait_ms_s = dly_ms_r;
`endif
      default:  wait_ms_s = 16'd0;
    endcase
  end

  // Prescaler is cleared on state entry, so the N-th ms completes exactly
  // N*TICK cycles later; a zero wait completes on the first cycle.
  assign ms_tick_s   = (tick_cnt_r == TICK_LAST);
  assign wait_over_s = (wait_ms_s == 16'd0) ||
                       (ms_tick_s && (ms_cnt_r == wait_ms_s - 16'd1));
  // A fresh index restarts the lookup; a stale decode is then discarded.
  assign start_s     = go_r || ((state_r == RUN) && (i2c_config_index != idx_prev_r));
  assign resolve_s   = (lk_r == 2'd2) && !start_s;

  // Decode of the registered ROM word for the looked-up pointer.
  always_comb begin
    dec_state_s = RUN;
    dec_size_s  = i2c_config_index + 10'd1;
    dec_load_s  = 1'b1;
    dec_done_s  = 1'b0;
`ifdef OV5640_CFG_DELAY_EN
    if (ptr_r >= LUT_SIZE) begin
      dec_state_s = DONE;
      dec_size_s  = i2c_config_index;
      dec_load_s  = 1'b0;
      dec_done_s  = 1'b1;
    end else if (entry_id(rom_data_s) == DELAY_ID) begin
      // Size = index parks the controller at IDLE for the delay.
      dec_state_s = DLY;
      dec_size_s  = i2c_config_index;
      dec_load_s  = 1'b0;
    end else begin
      dec_state_s = RUN;
    end
`else
    dec_size_s = LUT_SIZE;
    if (ptr_r >= LUT_SIZE) begin
      dec_state_s = DONE;
      dec_load_s  = 1'b0;
      dec_done_s  = 1'b1;
    end else begin
      dec_load_s = 1'b1;
    end
`endif
  end

  // Sequencer FSM, prescaler, lookup pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= PWR_WAIT;
      cmos_pwdn        <= 1'b1;
      cmos_rst_n       <= 1'b0;
      i2c_rst_n        <= 1'b0;
      i2c_config_size  <= 10'd0;
      i2c_config_data  <= 32'd0;
      cfg_done         <= 1'b0;
      tick_cnt_r       <= 32'd0;
      ms_cnt_r         <= 16'd0;
      go_r             <= 1'b0;
      lk_r             <= 2'd0;
      ptr_r            <= 10'd0;
      idx_prev_r       <= 10'd0;
`ifdef OV5640_CFG_DELAY_EN
      skip_r           <= 10'd0;
      dly_ms_r         <= 16'd0;
`endif
    end else begin
      idx_prev_r <= i2c_config_index;
      go_r       <= 1'b0;
      if (ms_tick_s) begin
        tick_cnt_r <= 32'd0;
        ms_cnt_r   <= ms_cnt_r + 16'd1;
      end else begin
        tick_cnt_r <= tick_cnt_r + 32'd1;
      end
      if (start_s) begin
        ptr_r <= ptr_nxt_s;
        lk_r  <= 2'd1;
      end else if (lk_r == 2'd1) begin
        lk_r <= 2'd2;
      end else begin
        lk_r <= 2'd0;
      end
      case (state_r)
        PWR_WAIT: begin
          if (wait_over_s) begin
            cmos_pwdn  <= 1'b0;
            state_r    <= PWDN_REL;
            tick_cnt_r <= 32'd0;
            ms_cnt_r   <= 16'd0;
          end
        end
        PWDN_REL: begin
          if (wait_over_s) begin
            cmos_rst_n <= 1'b1;
            state_r    <= RST_REL;
            tick_cnt_r <= 32'd0;
            ms_cnt_r   <= 16'd0;
          end
        end
        RST_REL, RUN: begin
          if (resolve_s) begin
            state_r         <= dec_state_s;
            i2c_config_size <= dec_size_s;
            if (dec_load_s) begin
              i2c_config_data <= rom_data_s;
            end
            cfg_done        <= dec_done_s;
            i2c_rst_n       <= 1'b1;
            tick_cnt_r      <= 32'd0;
            ms_cnt_r        <= 16'd0;
`ifdef OV5640_CFG_DELAY_EN
            dly_ms_r        <= entry_delay_ms(rom_data_s);
`endif
          end else if ((state_r == RST_REL) && !go_r && (lk_r == 2'd0) && wait_over_s) begin
            go_r <= 1'b1;
          end
        end
`ifdef OV5640_CFG_DELAY_EN
        DLY: begin
          if (wait_over_s) begin
            skip_r     <= skip_r + 10'd1;
            go_r       <= 1'b1;
            state_r    <= RUN;
            tick_cnt_r <= 32'd0;
            ms_cnt_r   <= 16'd0;
          end
        end
`endif
        DONE: begin
        end
        default: state_r <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// tb_ov5640_cfg_sequencer
// Self-checking bench: power-up timing, entry stepping with a randomized
// controller (random transfer lengths / retries), delay entries, completion,
// and mid-run reset. Expected behaviour comes from a table-level model that
// turns the register table into the sequence the controller should observe.
// Follows OV5640_CFG_DELAY_EN in the same way as the design.
module tb_ov5640_cfg_sequencer;

  localparam int         CLK_FREQ  = 10_000;
  localparam logic [9:0] LUT_SIZE  = 10'd12;
  localparam int         T_PWDN_MS = 5;
  localparam int         T_RST_MS  = 1;
  localparam int         T_SCCB_MS = 2;
  localparam int         TICK      = CLK_FREQ / 1000;
  localparam int         P_FALL    = T_PWDN_MS * TICK;
  localparam int         P_RST     = P_FALL + T_RST_MS * TICK;
  localparam int         P_REL     = P_RST + T_SCCB_MS * TICK + 3;
`ifdef OV5640_CFG_DELAY_EN
  localparam bit DELAY_EN = 1'b1;
`else
  localparam bit DELAY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmos_pwdn, cmos_rst_n, i2c_rst_n, cfg_done;
  logic [9:0]  i2c_config_index;
  logic [9:0]  i2c_config_size;
  logic [31:0] i2c_config_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] tbl [12];
  logic [31:0] vis [13];   // entries the controller should see, in order
  int          dly_ms [13];// total delay ms executed before visible entry k
  int          dly_n [13]; // number of delay entries before visible entry k
  int          vis_cnt;

  always #5 clk = ~clk;

  ov5640_cfg_sequencer #(
    .CLK_FREQ  (CLK_FREQ),
    .LUT_SIZE  (LUT_SIZE),
    .T_PWDN_MS (T_PWDN_MS),
    .T_RST_MS  (T_RST_MS),
    .T_SCCB_MS (T_SCCB_MS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmos_pwdn        (cmos_pwdn),
    .cmos_rst_n       (cmos_rst_n),
    .i2c_rst_n        (i2c_rst_n),
    .i2c_config_index (i2c_config_index),
    .i2c_config_size  (i2c_config_size),
    .i2c_config_data  (i2c_config_data),
    .cfg_done         (cfg_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] exp_size(input int n);
    if (!DELAY_EN) return LUT_SIZE;
    else if (n < vis_cnt) return 10'(n + 1);
    else return 10'(n);
  endfunction

  function automatic logic [9:0] exp_held(input int n);
    if (!DELAY_EN) return LUT_SIZE;
    else return 10'(n);
  endfunction

  task automatic build_model();
    int pm, pn;
    logic [31:0] w;
    tbl = '{32'h7831_0311, 32'h7830_0882, 32'hFF00_0005, 32'h7830_0842,
            32'h7831_0303, 32'hFF00_0000, 32'h7830_17FF, 32'h7830_18FF,
            32'h7830_341A, 32'h7830_3713, 32'h7831_0801, 32'h7836_3036};
    vis_cnt = 0; pm = 0; pn = 0;
    for (int i = 0; i < 12; i++) begin
      w = tbl[i];
      if (DELAY_EN && (w[31:24] == 8'hFF)) begin
        pm += int'(w[15:0]);
        pn++;
      end else begin
        vis[vis_cnt] = w; dly_ms[vis_cnt] = pm; dly_n[vis_cnt] = pn;
        vis_cnt++; pm = 0; pn = 0;
      end
    end
    dly_ms[vis_cnt] = pm;
    dly_n[vis_cnt]  = pn;
  endtask

  task automatic test_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) step();
    i2c_config_index = 10'd0;
    n_cmp++;
    if ({cmos_pwdn, cmos_rst_n, i2c_rst_n, cfg_done} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_pins: got pwdn/rst_n/i2c_rst_n/done=%b expected 1000",
               {cmos_pwdn, cmos_rst_n, i2c_rst_n, cfg_done});
    end
    n_cmp++;
    if (i2c_config_size !== 10'd0 || i2c_config_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_bus: got size=%0d data=%h expected 0/0",
               i2c_config_size, i2c_config_data);
    end
  endtask

  task automatic test_powerup();
    rst = 1'b0;
    for (int k = 1; k <= P_REL; k++) begin
      step();
      n_cmp++;
      if ({cmos_pwdn, cmos_rst_n, i2c_rst_n} !== {k < P_FALL, k >= P_RST, k >= P_REL}) begin
        n_err++;
        $display("FAIL powerup_pins cycle %0d: got %b expected %b", k,
                 {cmos_pwdn, cmos_rst_n, i2c_rst_n}, {k < P_FALL, k >= P_RST, k >= P_REL});
      end
    end
    n_cmp++;
    if (i2c_config_data !== vis[0] || i2c_config_size !== exp_size(0) || cfg_done !== 1'b0) begin
      n_err++;
      $display("FAIL powerup_entry0: got data=%h size=%0d done=%b expected %h/%0d/0",
               i2c_config_data, i2c_config_size, cfg_done, vis[0], exp_size(0));
    end
  endtask

  // Controller model: present, hold (transfer + retries), increment, repeat.
  task automatic test_stepping(input int stop_at);
    int n, lat, lo, hi, hold;
    bit reached;
    for (int i = 0; i < vis_cnt; i++) begin
      n_cmp++;
      if (i2c_config_data !== vis[i] || i2c_config_size !== exp_size(i) || cfg_done !== 1'b0) begin
        n_err++;
        $display("FAIL step_present idx %0d: got data=%h size=%0d done=%b expected %h/%0d/0",
                 i, i2c_config_data, i2c_config_size, cfg_done, vis[i], exp_size(i));
      end
      if (i == stop_at) return;
      hold = $urandom_range(12, 1);
      repeat (hold) begin
        step();
        n_cmp++;
        if (i2c_config_data !== vis[i] || i2c_config_size !== exp_size(i)) begin
          n_err++;
          $display("FAIL step_hold idx %0d: got data=%h size=%0d expected %h/%0d",
                   i, i2c_config_data, i2c_config_size, vis[i], exp_size(i));
        end
      end
      n = i + 1;
      i2c_config_index = 10'(n);
      lo = 3 + dly_ms[n] * TICK;
      hi = lo + 4 * dly_n[n];
      lat = 0;
      reached = 1'b0;
      while (!reached && lat < hi + 5) begin
        step();
        lat++;
        if (n < vis_cnt) reached = (i2c_config_data === vis[n]) && (i2c_config_size === exp_size(n));
        else reached = (cfg_done === 1'b1);
        if (!reached) begin
          n_cmp++;
          if (i2c_config_data !== vis[i] || i2c_config_size !== exp_held(n)) begin
            n_err++;
            $display("FAIL step_gap idx %0d cyc %0d: got data=%h size=%0d expected %h/%0d",
                     n, lat, i2c_config_data, i2c_config_size, vis[i], exp_held(n));
          end
        end
      end
      n_cmp++;
      if (!reached || lat < lo || lat > hi) begin
        n_err++;
        $display("FAIL step_latency idx %0d: got %0d cycles (reached=%0b) expected %0d..%0d",
                 n, lat, reached, lo, hi);
      end
    end
    n_cmp++;
    if (cfg_done !== 1'b1 || i2c_config_size !== exp_size(vis_cnt)) begin
      n_err++;
      $display("FAIL done_final: got done=%b size=%0d expected 1/%0d",
               cfg_done, i2c_config_size, exp_size(vis_cnt));
    end
  endtask

  task automatic test_done_sticky();
    repeat (20) begin
      step();
      n_cmp++;
      if (cfg_done !== 1'b1 || i2c_config_size !== exp_size(vis_cnt) || i2c_rst_n !== 1'b1) begin
        n_err++;
        $display("FAIL done_sticky: got done=%b size=%0d i2c_rst_n=%b expected 1/%0d/1",
                 cfg_done, i2c_config_size, i2c_rst_n, exp_size(vis_cnt));
      end
    end
  endtask

  task automatic test_mid_reset();
    test_reset(2);
    test_powerup();
    test_stepping(2);
    test_reset(1);
    test_powerup();
    test_stepping(-1);
    test_done_sticky();
  endtask

  initial begin
    rst = 1'b1;
    i2c_config_index = 10'd0;
    build_model();
    test_reset(3);
    test_powerup();
    test_stepping(-1);
    test_done_sticky();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
